// File: rtl/regdump_pkg.sv
// regdump_pkg -- shared definitions for the register-file debug dumper.
//
// Contents:
//   REG_ADDR_W : register address width of the CPU register file (32 registers)
//   REG_COUNT  : number of registers in the register file
//   state_t    : dumper FSM states (IDLE, READ, SEND, DONE)
package regdump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : regdump_pkg

// File: rtl/regfile_dumper_if.sv
// regfile_dumper_if -- bus bundle between the dumper, the register-file debug
// read port and the downstream debug stream consumer.
//
// Signals:
//   Dbg_addr  : address to the register-file debug read port (dumper drives)
//   Dbg_data  : combinational read data for Dbg_addr (register file drives)
//   out_valid : beat available (dumper drives)
//   out_ready : consumer accepts the beat (consumer drives)
//   out_addr  : register address of the current beat (dumper drives)
//   out_data  : register value of the current beat (dumper drives)
//
// Modports:
//   master : dumper side
//   slave  : register file / stream consumer side
interface regfile_dumper_if
  import regdump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = REG_ADDR_W
);

  logic [ADDR_W-1:0] Dbg_addr;
  logic [DATA_W-1:0] Dbg_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output Dbg_addr,
    input  Dbg_data,
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_data
  );

  modport slave (
    input  Dbg_addr,
    output Dbg_data,
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_data
  );

endinterface : regfile_dumper_if

// File: rtl/regfile_dumper.sv
// regfile_dumper -- sequential debug reader for the CPU register file.
//
// On a start pulse in IDLE it walks the inclusive range first_addr..last_addr
// (modulo 2^ADDR_W, so first > last wraps through the top address to 0) over
// the debug read port and emits one {address, data} beat per register on a
// valid/ready stream. It never writes the register file.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-high reset
//   start      : one-cycle dump request, sampled only in IDLE
//   first_addr : first register to dump, captured on start
//   last_addr  : final register to dump, captured on start
//   busy       : high whenever the FSM is not in IDLE
//   done       : one-cycle pulse when a dump completes
//   bus        : regfile_dumper_if.master (debug read port + output stream)
//
// Build option:
//   REGDUMP_SKIP_ZERO_EN : when defined, address 0 is never emitted; a READ
//                          on address 0 advances without visiting SEND.
module regfile_dumper
  import regdump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  regfile_dumper_if.master  bus
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W-1:0] w_end_nxt;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] w_out_addr_nxt;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              w_last;

  // The walk is inclusive of the end address, so the final beat is the one
  // taken while the counter equals the captured end.
  assign w_last = (r_cnt == r_end);

  // Next-state, counter and beat-capture logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_end_nxt      = r_end;
    w_out_addr_nxt = r_out_addr;
    w_out_data_nxt = r_out_data;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = READ;
          w_cnt_nxt   = first_addr;
          w_end_nxt   = last_addr;
        end else begin
          w_cnt_nxt   = ADDR_ZERO;
        end
      end
      READ: begin
`ifdef REGDUMP_SKIP_ZERO_EN
        if (r_cnt == ADDR_ZERO) begin
          // x0 is skipped: advance without presenting a beat.
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt   = r_cnt + ADDR_ONE;
          end
        end else begin
          w_state_nxt    = SEND;
          w_out_addr_nxt = r_cnt;
          w_out_data_nxt = bus.Dbg_data;
        end
`else
        w_state_nxt    = SEND;
        w_out_addr_nxt = r_cnt;
        w_out_data_nxt = bus.Dbg_data;
`endif
      end
      SEND: begin
        // The beat registers are untouched here, so the presented beat stays
        // stable through any stall even if the register file is written.
        if (bus.out_ready) begin
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = READ;
            w_cnt_nxt   = r_cnt + ADDR_ONE;
          end
        end else begin
          w_state_nxt = SEND;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = ADDR_ZERO;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = ADDR_ZERO;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers and status flags; the flags are decoded from the next
  // state so the outputs come straight from flops aligned with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= ADDR_ZERO;
      r_end      <= ADDR_ZERO;
      r_out_addr <= ADDR_ZERO;
      r_out_data <= DATA_ZERO;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_end      <= w_end_nxt;
      r_out_addr <= w_out_addr_nxt;
      r_out_data <= w_out_data_nxt;
      r_valid    <= (w_state_nxt == SEND);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
    end
  end

  assign bus.Dbg_addr  = r_cnt;
  assign bus.out_valid = r_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule : regfile_dumper

// File: doc/regfile_dumper.md
# regfile_dumper

Sequential debug reader for the CPU register file. On a start pulse it walks a programmed address range over a dedicated debug read port and emits one `{address, data}` beat per register on a valid/ready stream. The stream feeds the board display/UART debug path; the block never writes the register file.

## Interface
Parameters:
- `DATA_W`, default 32: register data width.
- `ADDR_W`, default 5: register address width (32 registers).

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: one-cycle request to begin a dump; sampled only in IDLE.
- `first_addr`, input, ADDR_W: first register to dump; captured on start.
- `last_addr`, input, ADDR_W: final register to dump; captured on start.
- `Dbg_addr`, output, ADDR_W: address driven to the register-file debug read port.
- `Dbg_data`, input, DATA_W: combinational read data for `Dbg_addr`, valid in the same cycle.
- `out_valid`, output, 1: beat available.
- `out_ready`, input, 1: consumer accepts the beat.
- `out_addr`, output, ADDR_W: register address of the current beat.
- `out_data`, output, DATA_W: register value of the current beat.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when a dump completes.

## Operation
- FSM states and transitions:
  - IDLE → READ on `start`. Latches `first_addr` into the address counter and `last_addr` into the end register.
  - READ → SEND. `Dbg_data` is captured into `out_data` and the counter into `out_addr`.
  - SEND holds `out_valid` until `out_valid && out_ready`. On that handshake: if counter == end, go to DONE; else increment the counter and go to READ.
  - DONE → IDLE, asserting `done` for exactly one cycle.
- `Dbg_addr` equals the counter at all times. The counter is 0 in IDLE.
- Address arithmetic is modulo 2^ADDR_W:
  - If `first_addr > last_addr`, the walk wraps through 31 to 0.
  - If `first_addr == last_addr`, exactly one beat is emitted.
- `out_addr` and `out_data` are stable while `out_valid` is high and not yet accepted.
- Data is sampled in the READ cycle. Register writes that land during SEND do not alter the held beat. The dump is not an atomic snapshot.
- `start` outside IDLE is ignored, with no queuing.
- Register x0 is dumped as whatever the port returns, which is 0 by register-file contract.

## Timing
- Reset values: `Dbg_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `busy`=0, `done`=0; state=IDLE.
- `start` at edge t gives READ in cycle t+1 and `out_valid`=1 from cycle t+2.
- Each beat costs 2 cycles (READ + SEND) with `out_ready` held high. A full 32-register dump ends with `done` 64 cycles after the start edge + 1.
- `out_ready` stalls of any length are allowed. `out_valid` never drops without a handshake.
- Asserting `rst` mid-dump immediately returns all outputs to reset values. No `done` pulse is emitted and the partial dump is discarded.

## Configuration
- `REGDUMP_SKIP_ZERO_EN`:
  - **Defined:** address 0 is never emitted. In READ, when the counter is 0 the FSM skips SEND: it goes to DONE if counter == end, else increments and stays in READ. A range of only x0 therefore yields no beats and `done` two cycles after start.
  - **Undefined:** every address in range is emitted, including x0.

## Structure
- Shared package `regdump_pkg`:
  - state enum: IDLE, READ, SEND, DONE;
  - `REG_ADDR_W`=5;
  - `REG_COUNT`=32.
- Single module, no sub-module. The FSM and counter are small enough to live together.

## Test plan
- Full range: first=0, last=31, `out_ready`=1, register file preloaded with reg[i]=i*0x11111111 → 32 beats in address order 0..31, data matching, `done` at start+65, `busy` low after.
- Single register: first=last=5, reg5=0xDEADBEEF → one beat `{5, 0xDEADBEEF}`, then `done`.
- Wrap range: first=30, last=1 → beats with addresses 30, 31, 0, 1.
- Backpressure: `out_ready` low for 7 cycles on beat 3 → beat held stable, no beat lost or duplicated, `start` pulses issued during the dump ignored.
- Reset mid-dump: `rst` after the 4th handshake → all outputs 0 immediately, no `done`; a subsequent start dumps normally.
- With `REGDUMP_SKIP_ZERO_EN`: first=0, last=2 → beats for addresses 1 and 2 only; first=last=0 → no beats, `done` at start+2.
